pry2oht_arb: RTL and testbench

//  Round-robin arbiter: picks one of WIDTH requesters and presents it as a registered one-hot grant

---
 rtl/pry2oht_arb.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_pry2oht_arb.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pry2oht_arb.sv
// Round-robin arbiter with registered one-hot grant and valid/ready handshake.
// Contains the priority-to-one-hot leaf (pry2oht_base), the recursive
// selection tree (pry2oht_tree) and the arbiter top (pry2oht_arb).

// Leaf: one-hot of the first set bit in scan order.
module pry2oht_base #(
  parameter int    WIDTH          = 2,
  parameter string DIRECTION      = "LSB",
  parameter int    IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] oht,
  output logic             any
);

  localparam bit MSB_FIRST = (DIRECTION == "MSB");

  assign any = |req;

  generate
    if (IMPLEMENTATION == 1) begin : g_arith
      // Two's-complement isolate-lowest-bit on a vector reordered so that
      // scan order always runs from bit 0 upward.
      logic [WIDTH-1:0] ord;
      logic [WIDTH-1:0] ord_oht;

      // Reorder the request into scan order.
      always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
          ord[i] = MSB_FIRST ? req[WIDTH-1-i] : req[i];
        end
      end

      assign ord_oht = ord & (~ord + {{(WIDTH-1){1'b0}}, 1'b1});

      // Map the isolated bit back to requester indices.
      always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
          oht[i] = MSB_FIRST ? ord_oht[WIDTH-1-i] : ord_oht[i];
        end
      end
    end else begin : g_scan
      logic found;

      // Linear priority scan; the first set bit in scan order wins.
      always_comb begin
        found = 1'b0;
        oht   = '0;
        if (MSB_FIRST) begin
          for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i] && !found) begin
              oht[i] = 1'b1;
              found  = 1'b1;
            end
          end
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (req[i] && !found) begin
              oht[i] = 1'b1;
              found  = 1'b1;
            end
          end
        end
      end
    end
  endgenerate

endmodule

// Tree: splits the request into SPLIT groups, resolves each group
// recursively, then picks the winning group with a leaf of width SPLIT.
module pry2oht_tree #(
  parameter int    WIDTH          = 32,
  parameter int    SPLIT          = 2,
  parameter string DIRECTION      = "LSB",
  parameter int    IMPLEMENTATION = 0
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] oht,
  output logic             any
);

  generate
    if (WIDTH <= SPLIT) begin : g_leaf
      pry2oht_base #(
        .WIDTH          (WIDTH),
        .DIRECTION      (DIRECTION),
        .IMPLEMENTATION (IMPLEMENTATION)
      ) u_base (
        .req (req),
        .oht (oht),
        .any (any)
      );
    end else begin : g_node
      localparam int SUB = WIDTH / SPLIT;

      logic [SPLIT-1:0] grp_any;
      logic [SPLIT-1:0] grp_oht;
      logic [WIDTH-1:0] sub_oht;

      for (genvar k = 0; k < SPLIT; k++) begin : g_sub
        pry2oht_tree #(
          .WIDTH          (SUB),
          .SPLIT          (SPLIT),
          .DIRECTION      (DIRECTION),
          .IMPLEMENTATION (IMPLEMENTATION)
        ) u_sub (
          .req (req[k*SUB +: SUB]),
          .oht (sub_oht[k*SUB +: SUB]),
          .any (grp_any[k])
        );

        // Only the winning group's local one-hot survives.
        assign oht[k*SUB +: SUB] = sub_oht[k*SUB +: SUB] & {SUB{grp_oht[k]}};
      end

      pry2oht_base #(
        .WIDTH          (SPLIT),
        .DIRECTION      (DIRECTION),
        .IMPLEMENTATION (IMPLEMENTATION)
      ) u_grp (
        .req (grp_any),
        .oht (grp_oht),
        .any (any)
      );
    end
  endgenerate

endmodule

// Arbiter top: rotating pointer, registered grant, stall and optional lock.
module pry2oht_arb #(
  parameter int    WIDTH          = 32,
  parameter int    SPLIT          = 2,
  parameter string DIRECTION      = "LSB",
  parameter bit    LOCK           = 1'b0,
  parameter int    IMPLEMENTATION = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt,
  output logic             vld,
  input  logic             rdy,
  input  logic             lst
);

  localparam bit MSB_FIRST = (DIRECTION == "MSB");

  // Pointer parks on the last index in scan order so the first grant after
  // reset goes to the first requester in scan order.
  function automatic logic [WIDTH-1:0] ptr_reset_value();
    logic [WIDTH-1:0] r;
    r = '0;
    if (MSB_FIRST) r[0] = 1'b1;
    else           r[WIDTH-1] = 1'b1;
    return r;
  endfunction

  localparam logic [WIDTH-1:0] PTR_RST = ptr_reset_value();

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_p0, state_n;
  logic [WIDTH-1:0] gnt_p0,   gnt_n;
  logic [WIDTH-1:0] ptr_p0,   ptr_n;
  logic             vld_p0,   vld_n;

  logic [WIDTH-1:0] ptr_eff;
  logic [WIDTH-1:0] msk;
  logic [WIDTH-1:0] oht_msk, oht_req, sel;
  logic             any_msk, any_req;
  logic             seen;
  logic             xfer;
  logic             release_beat;

  // While a grant is outstanding the current grant is the pointer for the
  // next selection, which makes back-to-back grants rotate without a bubble.
  assign ptr_eff = (state_p0 == GRANT) ? gnt_p0 : ptr_p0;

  // Keep only requests strictly after the pointer in scan order.
  always_comb begin
    seen = 1'b0;
    msk  = '0;
    if (MSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        msk[i] = req[i] & seen;
        seen   = seen | ptr_eff[i];
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        msk[i] = req[i] & seen;
        seen   = seen | ptr_eff[i];
      end
    end
  end

  pry2oht_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .DIRECTION      (DIRECTION),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_tree_msk (
    .req (msk),
    .oht (oht_msk),
    .any (any_msk)
  );

  pry2oht_tree #(
    .WIDTH          (WIDTH),
    .SPLIT          (SPLIT),
    .DIRECTION      (DIRECTION),
    .IMPLEMENTATION (IMPLEMENTATION)
  ) u_tree_req (
    .req (req),
    .oht (oht_req),
    .any (any_req)
  );

  // Masked winner if any, otherwise wrap around to the unmasked winner.
  assign sel = any_msk ? oht_msk : oht_req;

  assign xfer         = vld_p0 & rdy;
  assign release_beat = !LOCK || lst;

  // Next-state and next-grant decision.
  always_comb begin
    state_n = state_p0;
    gnt_n   = gnt_p0;
    vld_n   = vld_p0;
    ptr_n   = ptr_p0;
    case (state_p0)
      IDLE: begin
        if (any_req) begin
          gnt_n   = sel;
          vld_n   = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // A stall or a locked beat leaves grant and pointer untouched.
        if (xfer && release_beat) begin
          ptr_n = gnt_p0;
          if (any_req) begin
            gnt_n = sel;
          end else begin
            gnt_n   = '0;
            vld_n   = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        vld_n   = 1'b0;
      end
    endcase
  end

  // Registered grant stage; reset clears outputs immediately and drops any lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      gnt_p0   <= '0;
      vld_p0   <= 1'b0;
      ptr_p0   <= PTR_RST;
    end else begin
      state_p0 <= state_n;
      gnt_p0   <= gnt_n;
      vld_p0   <= vld_n;
      ptr_p0   <= ptr_n;
    end
  end

  assign gnt = gnt_p0;
  assign vld = vld_p0;

`ifndef SYNTHESIS
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    vld_p0 |-> $onehot(gnt_p0));

  a_gnt_zero_idle : assert property (@(posedge clk) disable iff (!rst_n)
    !vld_p0 |-> (gnt_p0 == '0));

  a_gnt_stable_stall : assert property (@(posedge clk) disable iff (!rst_n)
    (vld_p0 && !rdy) |=> $stable(gnt_p0));

`ifdef PRY2OHT_ARB_CHECK_REQ_HOLD
  // Opt-in: some integrations retract requests while stalled on purpose.
  a_req_held : assert property (@(posedge clk) disable iff (!rst_n)
    (vld_p0 && !rdy) |-> ((req & gnt_p0) == gnt_p0));
`endif

  if (!LOCK) begin : g_fair
    int unsigned wait_cnt [WIDTH];

    // Count transfers that went elsewhere while a requester kept asking.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < WIDTH; i++) wait_cnt[i] <= 0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (!req[i] || (xfer && gnt_p0[i])) wait_cnt[i] <= 0;
          else if (xfer)                      wait_cnt[i] <= wait_cnt[i] + 1;
        end
      end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_fair_chk
      a_fair : assert property (@(posedge clk) disable iff (!rst_n)
        wait_cnt[g] < WIDTH);
    end
  end
`endif

endmodule

// File: tb/tb_pry2oht_arb.sv
// Bench for pry2oht_arb: three instances (LSB/unlocked, LSB/locked,
// MSB/unlocked) share one stimulus stream; directed scenarios plus a
// randomized run against a scan-order reference model.
module tb_pry2oht_arb;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] req = '0;
  logic         rdy = 1'b0;
  logic         lst = 1'b0;

  logic [W-1:0] gnt_l, gnt_k, gnt_m;
  logic         vld_l, vld_k, vld_m;

  logic [W-1:0] gnt_a [3];
  logic         vld_a [3];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: per instance, valid flag, granted index, last released index.
  bit m_vld  [3];
  int m_g    [3];
  int m_last [3];

  always #5 clk = ~clk;

  pry2oht_arb #(.WIDTH(W), .SPLIT(2), .DIRECTION("LSB"), .LOCK(1'b0), .IMPLEMENTATION(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_l), .vld(vld_l), .rdy(rdy), .lst(lst));

  pry2oht_arb #(.WIDTH(W), .SPLIT(2), .DIRECTION("LSB"), .LOCK(1'b1), .IMPLEMENTATION(1)) dut_k (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_k), .vld(vld_k), .rdy(rdy), .lst(lst));

  pry2oht_arb #(.WIDTH(W), .SPLIT(2), .DIRECTION("MSB"), .LOCK(1'b0), .IMPLEMENTATION(0)) dut_m (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_m), .vld(vld_m), .rdy(rdy), .lst(lst));

  assign gnt_a[0] = gnt_l;
  assign gnt_a[1] = gnt_k;
  assign gnt_a[2] = gnt_m;
  assign vld_a[0] = vld_l;
  assign vld_a[1] = vld_k;
  assign vld_a[2] = vld_m;

  function automatic bit is_lock(input int i);
    return (i == 1);
  endfunction

  function automatic bit is_msb(input int i);
    return (i == 2);
  endfunction

  // Next requester after 'last' walking in scan order with wrap-around.
  function automatic int scan_next(input logic [W-1:0] r, input int last, input bit msb);
    for (int k = 1; k <= W; k++) begin
      int idx;
      idx = msb ? ((last - k + W) % W) : ((last + k) % W);
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_gnt(input int i);
    logic [W-1:0] v;
    v = '0;
    if (m_vld[i]) v[m_g[i]] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_vld[i]  = 1'b0;
      m_g[i]    = 0;
      m_last[i] = is_msb(i) ? 0 : W - 1;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (!m_vld[i]) begin
        if (req != '0) begin
          m_g[i]   = scan_next(req, m_last[i], is_msb(i));
          m_vld[i] = 1'b1;
        end
      end else if (rdy && (!is_lock(i) || lst)) begin
        m_last[i] = m_g[i];
        if (req != '0) m_g[i] = scan_next(req, m_last[i], is_msb(i));
        else           m_vld[i] = 1'b0;
      end
    end
  endtask

  // Apply inputs for one cycle, advance the model with them, sample 1 unit after the edge.
  task automatic step(input logic [W-1:0] r, input logic y, input logic l);
    req = r;
    rdy = y;
    lst = l;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    rdy   = 1'b0;
    lst   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    step(4'b1111, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (vld_a[i] !== 1'b0 || gnt_a[i] !== '0) begin
        n_err++;
        $display("FAIL reset inst%0d: vld=%b gnt=%b expected vld=0 gnt=0000", i, vld_a[i], gnt_a[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_round_robin();
    logic [W-1:0] exp_lsb [4];
    logic [W-1:0] exp_msb [4];
    exp_lsb = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
    exp_msb = '{4'b1000, 4'b0010, 4'b0001, 4'b1000};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(4'b1011, 1'b1, 1'b1);
      n_vec++;
      if (gnt_l !== exp_lsb[k] || vld_l !== 1'b1) begin
        n_err++;
        $display("FAIL rr_lsb beat%0d: gnt=%b vld=%b expected %b vld=1", k, gnt_l, vld_l, exp_lsb[k]);
      end
      n_vec++;
      if (gnt_m !== exp_msb[k] || vld_m !== 1'b1) begin
        n_err++;
        $display("FAIL rr_msb beat%0d: gnt=%b vld=%b expected %b vld=1", k, gnt_m, vld_m, exp_msb[k]);
      end
      n_vec++;
      if (gnt_k !== exp_lsb[k]) begin
        n_err++;
        $display("FAIL rr_lock_lst1 beat%0d: gnt=%b expected %b", k, gnt_k, exp_lsb[k]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(4'b0010, 1'b0, 1'b0);
    n_vec++;
    if (gnt_l !== 4'b0010 || vld_l !== 1'b1) begin
      n_err++;
      $display("FAIL stall_first: gnt=%b vld=%b expected 0010 vld=1", gnt_l, vld_l);
    end
    for (int k = 0; k < 3; k++) begin
      step(4'b0100, 1'b0, 1'b0);
      n_vec++;
      if (gnt_l !== 4'b0010 || vld_l !== 1'b1) begin
        n_err++;
        $display("FAIL stall_hold%0d: gnt=%b vld=%b expected 0010 vld=1", k, gnt_l, vld_l);
      end
    end
    step(4'b0100, 1'b1, 1'b0);
    n_vec++;
    if (gnt_l !== 4'b0100 || vld_l !== 1'b1) begin
      n_err++;
      $display("FAIL stall_release: gnt=%b vld=%b expected 0100 vld=1", gnt_l, vld_l);
    end
  endtask

  task automatic test_lock();
    logic [W-1:0] exp_k [4];
    logic         lst_seq [4];
    exp_k   = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    lst_seq = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(4'b0011, 1'b1, lst_seq[k]);
      n_vec++;
      if (gnt_k !== exp_k[k] || vld_k !== 1'b1) begin
        n_err++;
        $display("FAIL lock beat%0d: gnt=%b vld=%b expected %b vld=1", k, gnt_k, vld_k, exp_k[k]);
      end
    end
  endtask

  task automatic test_idle_return();
    do_reset();
    step(4'b0001, 1'b1, 1'b0);
    n_vec++;
    if (gnt_l !== 4'b0001 || vld_l !== 1'b1) begin
      n_err++;
      $display("FAIL idle_first: gnt=%b vld=%b expected 0001 vld=1", gnt_l, vld_l);
    end
    step(4'b0000, 1'b1, 1'b0);
    n_vec++;
    if (gnt_l !== 4'b0000 || vld_l !== 1'b0) begin
      n_err++;
      $display("FAIL idle_drop: gnt=%b vld=%b expected 0000 vld=0", gnt_l, vld_l);
    end
    step(4'b0100, 1'b1, 1'b0);
    n_vec++;
    if (gnt_l !== 4'b0100 || vld_l !== 1'b1) begin
      n_err++;
      $display("FAIL idle_regrant: gnt=%b vld=%b expected 0100 vld=1", gnt_l, vld_l);
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    step(4'b0011, 1'b1, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    n_vec++;
    if (gnt_k !== 4'b0001 || vld_k !== 1'b1) begin
      n_err++;
      $display("FAIL midlock_held: gnt=%b vld=%b expected 0001 vld=1", gnt_k, vld_k);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (gnt_k !== 4'b0000 || vld_k !== 1'b0) begin
      n_err++;
      $display("FAIL midlock_async_clear: gnt=%b vld=%b expected 0000 vld=0", gnt_k, vld_k);
    end
    #1;
    rst_n = 1'b1;
    model_reset();
    step(4'b1111, 1'b1, 1'b0);
    n_vec++;
    if (gnt_k !== 4'b0001 || vld_k !== 1'b1) begin
      n_err++;
      $display("FAIL midlock_after_reset: gnt=%b vld=%b expected 0001 vld=1", gnt_k, vld_k);
    end
    n_vec++;
    if (gnt_m !== 4'b1000) begin
      n_err++;
      $display("FAIL msb_after_reset: gnt=%b expected 1000", gnt_m);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] r;
    do_reset();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      // Requests are sticky most of the time so long waits get exercised.
      if ($urandom_range(0, 3) == 0) r = W'($urandom_range(0, 15));
      else                           r = r | W'($urandom_range(0, 15) & $urandom_range(0, 15));
      step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (gnt_a[i] !== exp_gnt(i) || vld_a[i] !== m_vld[i]) begin
          n_err++;
          $display("FAIL random c%0d inst%0d: gnt=%b vld=%b expected %b vld=%b",
                   c, i, gnt_a[i], vld_a[i], exp_gnt(i), m_vld[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_round_robin();
    test_stall();
    test_lock();
    test_idle_return();
    test_reset_mid_lock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
